// File: rtl/uart_mem_loader_if.sv
// ----------------------------------------------------------------------------
// uart_mem_loader_if
//   Bundles the byte-stream input, the instruction/data RAM write ports and
//   the status/debug signals of uart_mem_loader.
//
//   Handshake: rxValid is a one-cycle strobe with no back-pressure. In any
//   cycle where rxValid=1, rxByte carries one received byte and the loader
//   consumes it. No ready signal exists, so the loader accepts one byte
//   every cycle. start is a one-cycle pulse. Each RAM write enable is a
//   one-cycle pulse, and its address and data are valid in that same cycle.
//
//   Modports:
//     master : upstream side (UART receiver / top FSM). Drives start,
//              rxValid and rxByte. Observes everything else.
//     slave  : the loader itself.
//   Signals:
//     start, rxValid, rxByte[7:0]                   -> loader
//     insMemWrEn, insMemAddr, insMemDataOut         <- loader
//     dataMemWrEn, dataMemAddr, dataMemDataOut      <- loader
//     busy, done, state[1:0] (FSM state for debug)  <- loader
// ----------------------------------------------------------------------------
interface uart_mem_loader_if #(
    parameter int CORE_COUNT          = 1,
    parameter int REG_WIDTH           = 12,
    parameter int INS_WIDTH           = 8,
    parameter int INS_MEM_ADDR_WIDTH  = 8,
    parameter int DATA_MEM_ADDR_WIDTH = 12
);
    logic                            start;
    logic                            rxValid;
    logic [7:0]                      rxByte;
    logic                            insMemWrEn;
    logic [INS_MEM_ADDR_WIDTH-1:0]   insMemAddr;
    logic [INS_WIDTH-1:0]            insMemDataOut;
    logic                            dataMemWrEn;
    logic [DATA_MEM_ADDR_WIDTH-1:0]  dataMemAddr;
    logic [CORE_COUNT*REG_WIDTH-1:0] dataMemDataOut;
    logic                            busy;
    logic                            done;
    logic [1:0]                      state;

    modport master (
        output start, rxValid, rxByte,
        input  insMemWrEn, insMemAddr, insMemDataOut,
        input  dataMemWrEn, dataMemAddr, dataMemDataOut,
        input  busy, done, state
    );

    modport slave (
        input  start, rxValid, rxByte,
        output insMemWrEn, insMemAddr, insMemDataOut,
        output dataMemWrEn, dataMemAddr, dataMemDataOut,
        output busy, done, state
    );
endinterface

// File: rtl/uart_mem_loader.sv
// ----------------------------------------------------------------------------
// uart_mem_loader
//   Loads a program and then data words from a UART byte stream into the
//   instruction and data RAMs.
//   - After start, the first INS_LOAD_COUNT bytes are written one per
//     instruction address.
//   - Each group of 2*CORE_COUNT bytes after that forms one data word. Each
//     lane takes two bytes, lane 0 first: the low byte gives lane bits
//     [7:0], and the low nibble of the next byte gives bits [11:8].
//   - After DATA_LOAD_COUNT words the block reports done.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-high reset
//     bus : uart_mem_loader_if.slave (byte input, RAM write ports, status,
//           debug state)
//   All outputs are registered. Each write pulse appears one cycle after the
//   rxValid of the byte that completes it.
// ----------------------------------------------------------------------------
module uart_mem_loader #(
    parameter int CORE_COUNT          = 1,
    parameter int REG_WIDTH           = 12,
    parameter int INS_WIDTH           = 8,
    parameter int INS_MEM_ADDR_WIDTH  = 8,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int INS_LOAD_COUNT      = 256,
    parameter int DATA_LOAD_COUNT     = 4096
) (
    input logic               clk,
    input logic               rst,
    uart_mem_loader_if.slave  bus
);
    localparam int IA  = INS_MEM_ADDR_WIDTH;
    localparam int DA  = DATA_MEM_ADDR_WIDTH;
    localparam int DW  = CORE_COUNT * REG_WIDTH;
    localparam int BCW = (2 * CORE_COUNT > 1) ? $clog2(2 * CORE_COUNT) : 1;

    localparam logic [IA-1:0]  INS_LAST  = IA'(INS_LOAD_COUNT - 1);
    localparam logic [DA-1:0]  DATA_LAST = DA'(DATA_LOAD_COUNT - 1);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(2 * CORE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_INS  = 2'd1,
        LOAD_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t          state_q;
    logic [IA-1:0]   ins_idx_q;
    logic [DA-1:0]   word_idx_q;
    logic [BCW-1:0]  byte_cnt_q;
    logic [DW-1:0]   lanes_q;
    logic            data_last_q;   // final word written; enter DONE next cycle

    logic            ins_we_q;
    logic [IA-1:0]   ins_addr_q;
    logic [INS_WIDTH-1:0] ins_data_q;
    logic            data_we_q;
    logic [DA-1:0]   data_addr_q;
    logic [DW-1:0]   data_out_q;
    logic            busy_q;
    logic            done_q;

    // Assembly register with the incoming byte merged into its lane slot.
    // An even byte count means the low byte of a lane. An odd count means
    // the high nibble, and the top nibble of that byte is dropped.
    logic [DW-1:0] lanes_d;
    always_comb begin
        lanes_d = lanes_q;
        for (int k = 0; k < CORE_COUNT; k++) begin
            if (byte_cnt_q == BCW'(2 * k)) begin
                lanes_d[REG_WIDTH*k +: 8] = bus.rxByte;
            end else if (byte_cnt_q == BCW'(2 * k + 1)) begin
                lanes_d[REG_WIDTH*k + 8 +: 4] = bus.rxByte[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ins_idx_q   <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            lanes_q     <= '0;
            data_last_q <= 1'b0;
            ins_we_q    <= 1'b0;
            ins_addr_q  <= '0;
            ins_data_q  <= '0;
            data_we_q   <= 1'b0;
            data_addr_q <= '0;
            data_out_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Write enables are pulses; only a completing byte raises them.
            ins_we_q  <= 1'b0;
            data_we_q <= 1'b0;

            case (state_q)
                IDLE, DONE: begin
                    // rxValid is ignored here, even when it arrives with start.
                    if (bus.start) begin
                        state_q     <= LOAD_INS;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        ins_idx_q   <= '0;
                        word_idx_q  <= '0;
                        byte_cnt_q  <= '0;
                        lanes_q     <= '0;
                        data_last_q <= 1'b0;
                    end
                end

                LOAD_INS: begin
                    if (bus.rxValid) begin
                        ins_we_q   <= 1'b1;
                        ins_addr_q <= ins_idx_q;
                        ins_data_q <= INS_WIDTH'(bus.rxByte);
                        // The index stops at the last address; the state
                        // advances together with the final write.
                        if (ins_idx_q == INS_LAST) begin
                            state_q <= LOAD_DATA;
                        end else begin
                            ins_idx_q <= ins_idx_q + 1'b1;
                        end
                    end
                end

                LOAD_DATA: begin
                    if (data_last_q) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        data_last_q <= 1'b0;
                        byte_cnt_q  <= '0;
                        lanes_q     <= '0;
                    end else if (bus.rxValid) begin
                        if (byte_cnt_q == BYTE_LAST) begin
                            data_we_q   <= 1'b1;
                            data_addr_q <= word_idx_q;
                            data_out_q  <= lanes_d;
                            byte_cnt_q  <= '0;
                            lanes_q     <= '0;
                            if (word_idx_q == DATA_LAST) begin
                                data_last_q <= 1'b1;
                            end else begin
                                word_idx_q <= word_idx_q + 1'b1;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            lanes_q    <= lanes_d;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.insMemWrEn     = ins_we_q;
    assign bus.insMemAddr     = ins_addr_q;
    assign bus.insMemDataOut  = ins_data_q;
    assign bus.dataMemWrEn    = data_we_q;
    assign bus.dataMemAddr    = data_addr_q;
    assign bus.dataMemDataOut = data_out_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.state          = state_q;
endmodule

// File: tb/tb_uart_mem_loader.sv
module tb_uart_mem_loader;
    localparam int CC = 2;
    localparam int IA = 8;
    localparam int DA = 12;
    localparam int DW = CC * 12;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INS  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    uart_mem_loader_if #(
        .CORE_COUNT(CC), .REG_WIDTH(12), .INS_WIDTH(8),
        .INS_MEM_ADDR_WIDTH(IA), .DATA_MEM_ADDR_WIDTH(DA)
    ) bus ();

    uart_mem_loader #(
        .CORE_COUNT(CC), .REG_WIDTH(12), .INS_WIDTH(8),
        .INS_MEM_ADDR_WIDTH(IA), .DATA_MEM_ADDR_WIDTH(DA),
        .INS_LOAD_COUNT(3), .DATA_LOAD_COUNT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge. A byte is sampled on the next rising
    // edge, so its write is visible when send_byte returns.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rxValid = 1'b1;
        bus.rxByte  = b;
        @(negedge clk);
        bus.rxValid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.insMemWrEn, bus.insMemAddr, bus.insMemDataOut, bus.dataMemWrEn,
             bus.dataMemAddr, bus.dataMemDataOut, bus.busy, bus.done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got ins_we=%0b ins_a=%0h ins_d=%0h d_we=%0b d_a=%0h d_d=%0h busy=%0b done=%0b, want all 0",
                     bus.insMemWrEn, bus.insMemAddr, bus.insMemDataOut, bus.dataMemWrEn,
                     bus.dataMemAddr, bus.dataMemDataOut, bus.busy, bus.done);
        end
        vectors++;
        if (bus.state !== S_IDLE) begin
            miscompares++;
            $display("FAIL reset_state got %0d want %0d", bus.state, S_IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_ins();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        pulse_start();
        vectors++;
        if (bus.busy !== 1'b1 || bus.state !== S_INS) begin
            miscompares++;
            $display("FAIL start_busy got busy=%0b state=%0d want busy=1 state=1", bus.busy, bus.state);
        end
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i]);
            vectors++;
            if (bus.insMemWrEn !== 1'b1 || bus.insMemAddr !== IA'(i) || bus.insMemDataOut !== bytes[i]) begin
                miscompares++;
                $display("FAIL ins_write%0d got we=%0b addr=%0h data=%0h want we=1 addr=%0h data=%0h",
                         i, bus.insMemWrEn, bus.insMemAddr, bus.insMemDataOut, i, bytes[i]);
            end
        end
        vectors++;
        if (bus.state !== S_DATA || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ins_to_data got state=%0d busy=%0b want state=2 busy=1", bus.state, bus.busy);
        end
        @(negedge clk);
        vectors++;
        if (bus.insMemWrEn !== 1'b0 || bus.insMemAddr !== 8'h02 || bus.insMemDataOut !== 8'hC3) begin
            miscompares++;
            $display("FAIL ins_hold got we=%0b addr=%0h data=%0h want we=0 addr=2 data=c3",
                     bus.insMemWrEn, bus.insMemAddr, bus.insMemDataOut);
        end
    endtask

    task automatic test_load_data();
        logic [7:0]    w0 [4];
        logic [7:0]    w1 [4];
        w0[0] = 8'h34; w0[1] = 8'hF2; w0[2] = 8'h78; w0[3] = 8'h06;
        w1[0] = 8'hFF; w1[1] = 8'h0F; w1[2] = 8'h00; w1[3] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            send_byte(w0[i]);
            vectors++;
            if (bus.dataMemWrEn !== 1'b0 || bus.insMemWrEn !== 1'b0) begin
                miscompares++;
                $display("FAIL data_partial%0d got d_we=%0b i_we=%0b want 0 0", i, bus.dataMemWrEn, bus.insMemWrEn);
            end
        end
        send_byte(w0[3]);
        vectors++;
        if (bus.dataMemWrEn !== 1'b1 || bus.dataMemAddr !== 12'h000 || bus.dataMemDataOut !== 24'h678234) begin
            miscompares++;
            $display("FAIL data_word0 got we=%0b addr=%0h data=%06h want we=1 addr=0 data=678234",
                     bus.dataMemWrEn, bus.dataMemAddr, bus.dataMemDataOut);
        end
        for (int i = 0; i < 4; i++) send_byte(w1[i]);
        vectors++;
        if (bus.dataMemWrEn !== 1'b1 || bus.dataMemAddr !== 12'h001 || bus.dataMemDataOut !== 24'h000FFF) begin
            miscompares++;
            $display("FAIL data_word1 got we=%0b addr=%0h data=%06h want we=1 addr=1 data=000fff",
                     bus.dataMemWrEn, bus.dataMemAddr, bus.dataMemDataOut);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.state !== S_DONE || bus.dataMemWrEn !== 1'b0) begin
            miscompares++;
            $display("FAIL done_flags got done=%0b busy=%0b state=%0d d_we=%0b want 1 0 3 0",
                     bus.done, bus.busy, bus.state, bus.dataMemWrEn);
        end
        send_byte(8'h11);
        vectors++;
        if (bus.insMemWrEn !== 1'b0 || bus.dataMemWrEn !== 1'b0 || bus.dataMemAddr !== 12'h001) begin
            miscompares++;
            $display("FAIL done_ignores_rx got i_we=%0b d_we=%0b d_a=%0h want 0 0 1",
                     bus.insMemWrEn, bus.dataMemWrEn, bus.dataMemAddr);
        end
    endtask

    task automatic test_restart_from_done();
        pulse_start();
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.state !== S_INS) begin
            miscompares++;
            $display("FAIL restart_flags got done=%0b busy=%0b state=%0d want 0 1 1", bus.done, bus.busy, bus.state);
        end
        send_byte(8'h5A);
        vectors++;
        if (bus.insMemWrEn !== 1'b1 || bus.insMemAddr !== 8'h00 || bus.insMemDataOut !== 8'h5A) begin
            miscompares++;
            $display("FAIL restart_ins0 got we=%0b addr=%0h data=%0h want 1 0 5a",
                     bus.insMemWrEn, bus.insMemAddr, bus.insMemDataOut);
        end
        pulse_start();   // ignored while busy
        send_byte(8'h6B);
        vectors++;
        if (bus.insMemWrEn !== 1'b1 || bus.insMemAddr !== 8'h01 || bus.insMemDataOut !== 8'h6B) begin
            miscompares++;
            $display("FAIL start_while_busy got we=%0b addr=%0h data=%0h want 1 1 6b",
                     bus.insMemWrEn, bus.insMemAddr, bus.insMemDataOut);
        end
        send_byte(8'h7C);
        vectors++;
        if (bus.insMemAddr !== 8'h02 || bus.state !== S_DATA) begin
            miscompares++;
            $display("FAIL restart_ins2 got addr=%0h state=%0d want 2 2", bus.insMemAddr, bus.state);
        end
    endtask

    task automatic test_reset_mid_load();
        send_byte(8'h12);
        send_byte(8'h03);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.insMemAddr, bus.insMemDataOut, bus.busy, bus.done, bus.state,
             bus.dataMemWrEn, bus.insMemWrEn} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got i_a=%0h i_d=%0h busy=%0b done=%0b state=%0d want all 0",
                     bus.insMemAddr, bus.insMemDataOut, bus.busy, bus.done, bus.state);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        send_byte(8'h42);
        vectors++;
        if (bus.insMemWrEn !== 1'b1 || bus.insMemAddr !== 8'h00 || bus.insMemDataOut !== 8'h42 ||
            bus.dataMemWrEn !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_ins got i_we=%0b addr=%0h data=%0h d_we=%0b want 1 0 42 0",
                     bus.insMemWrEn, bus.insMemAddr, bus.insMemDataOut, bus.dataMemWrEn);
        end
    endtask

    task automatic test_start_with_rx();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.rxValid = 1'b1;
        bus.rxByte  = 8'h55;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.rxValid = 1'b0;
        vectors++;
        if (bus.insMemWrEn !== 1'b0 || bus.state !== S_INS) begin
            miscompares++;
            $display("FAIL start_rx_ignored got we=%0b state=%0d want 0 1", bus.insMemWrEn, bus.state);
        end
        send_byte(8'h66);
        vectors++;
        if (bus.insMemWrEn !== 1'b1 || bus.insMemAddr !== 8'h00 || bus.insMemDataOut !== 8'h66) begin
            miscompares++;
            $display("FAIL start_rx_next got we=%0b addr=%0h data=%0h want 1 0 66",
                     bus.insMemWrEn, bus.insMemAddr, bus.insMemDataOut);
        end
    endtask

    // Continues from test_start_with_rx: one instruction already written.
    task automatic test_back_to_back();
        logic [7:0]    s [10];
        logic [DW-1:0] exp_q [$];
        s[0] = 8'h77; s[1] = 8'h88;
        s[2] = 8'h01; s[3] = 8'h02; s[4] = 8'h03; s[5] = 8'h04;
        s[6] = 8'hAB; s[7] = 8'hCD; s[8] = 8'hEF; s[9] = 8'h10;
        exp_q.push_back(24'h403201);
        exp_q.push_back(24'h0EFDAB);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            // Outputs now reflect byte i-1, which was sampled on the last rising edge.
            if (i == 1 || i == 2) begin
                vectors++;
                if (bus.insMemWrEn !== 1'b1 || bus.insMemAddr !== IA'(i) || bus.insMemDataOut !== s[i-1]) begin
                    miscompares++;
                    $display("FAIL b2b_ins%0d got we=%0b addr=%0h data=%0h want 1 %0h %0h",
                             i, bus.insMemWrEn, bus.insMemAddr, bus.insMemDataOut, i, s[i-1]);
                end
            end else if (i == 6 || i == 10) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_queue_empty at byte %0d", i);
                end else if (bus.dataMemWrEn !== 1'b1 || bus.dataMemAddr !== DA'((i - 6) / 4) ||
                             bus.dataMemDataOut !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL b2b_data%0d got we=%0b addr=%0h data=%06h want 1 %0h %06h",
                             i, bus.dataMemWrEn, bus.dataMemAddr, bus.dataMemDataOut, (i - 6) / 4, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end else if (i >= 3) begin
                vectors++;
                if (bus.dataMemWrEn !== 1'b0 || bus.insMemWrEn !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_nowrite%0d got d_we=%0b i_we=%0b want 0 0", i, bus.dataMemWrEn, bus.insMemWrEn);
                end
            end
            if (i < 10) begin
                bus.rxValid = 1'b1;
                bus.rxByte  = s[i];
            end else begin
                bus.rxValid = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_done got done=%0b pending=%0d want 1 0", bus.done, exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.rxValid = 1'b0;
        bus.rxByte  = 8'h00;
        test_reset();
        test_load_ins();
        test_load_data();
        test_restart_from_done();
        test_reset_mid_load();
        test_start_with_rx();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
